// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard scoreboard for the in-order pipeline: stalls fetch/decode, bubbles ID/EX.
// Define FORWARD_EN for bypass selects and load-use-only stalling.
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_we_i,
    input  logic              id_load_i,
    input  logic              flush_i,
`ifdef FORWARD_EN
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
`endif
    output logic              stall_o,
    output logic              bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              load;
    } slot_t;

    slot_t s0, s1, s2;
    slot_t s0Next;
    logic  hazard;
    logic  hz1, hz2;
    logic  unusedLoad;

    function automatic logic hit(input slot_t s, input logic [REG_AW-1:0] r);
        return s.valid && (s.rd == r) && (r != '0);
    endfunction

`ifdef FORWARD_EN
    // Youngest producer wins when several slots hold the same rd.
    function automatic logic [1:0] fwdSel(
        input logic              use_,
        input logic [REG_AW-1:0] r,
        input slot_t             a,
        input slot_t             b,
        input slot_t             c
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_ && r != '0) begin
            if (hit(a, r))      sel = 2'b01;
            else if (hit(b, r)) sel = 2'b10;
            else if (hit(c, r)) sel = 2'b11;
        end
        return sel;
    endfunction

    assign hz1 = id_use_rs1_i && hit(s0, id_rs1_i) && s0.load;
    assign hz2 = id_use_rs2_i && hit(s0, id_rs2_i) && s0.load;
    assign unusedLoad = s1.load ^ s2.load;

    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (rst_n) begin
            fwd_a_o = fwdSel(id_use_rs1_i, id_rs1_i, s0, s1, s2);
            fwd_b_o = fwdSel(id_use_rs2_i, id_rs2_i, s0, s1, s2);
        end
    end
`else
    // No bypass network: the bank does not forward same-cycle writes, so WB counts too.
    assign hz1 = id_use_rs1_i &&
                 (hit(s0, id_rs1_i) || hit(s1, id_rs1_i) || hit(s2, id_rs1_i));
    assign hz2 = id_use_rs2_i &&
                 (hit(s0, id_rs2_i) || hit(s1, id_rs2_i) || hit(s2, id_rs2_i));
    assign unusedLoad = s0.load ^ s1.load ^ s2.load;
`endif

    assign hazard = id_valid_i && (hz1 || hz2);

    always_comb begin
        stall_o  = rst_n && hazard && !flush_i;
        bubble_o = !rst_n || hazard || flush_i || !id_valid_i;
        s0Next   = '0;
        if (id_valid_i && !hazard && !flush_i && id_we_i && id_rd_i != '0) begin
            s0Next.valid = 1'b1;
            s0Next.rd    = id_rd_i;
            s0Next.load  = id_load_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            stall_cnt_o <= '0;
        end else begin
            s0 <= s0Next;
            s1 <= s0;
            s2 <= s1;
            if (stall_o && stall_cnt_o != {CNT_W{1'b1}})
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a queue scoreboard.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              idValid;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              use1, use2, we, ld, flush;
    logic              stall, bubble;
    logic [CNT_W-1:0]  cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .id_valid_i(idValid),
        .id_rs1_i(rs1),
        .id_rs2_i(rs2),
        .id_use_rs1_i(use1),
        .id_use_rs2_i(use2),
        .id_rd_i(rd),
        .id_we_i(we),
        .id_load_i(ld),
        .flush_i(flush),
        .stall_o(stall),
        .bubble_o(bubble),
        .stall_cnt_o(cnt)
    );

    typedef struct {
        logic       rstn;
        logic       valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       fl;
        logic       chk;
        logic       eStall;
        logic       eBubble;
        int         eCnt;
        string      name;
    } vec_t;

    typedef struct {
        logic  eStall;
        logic  eBubble;
        int    eCnt;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic v(input logic rstn_, input logic valid_,
                     input int rs1_, input int rs2_, input logic u1_, input logic u2_,
                     input int rd_, input logic we_, input logic fl_, input logic chk_,
                     input logic es, input logic eb, input int ec, input string nm);
        vec_t t;
        t.rstn = rstn_; t.valid = valid_;
        t.rs1 = 5'(rs1_); t.rs2 = 5'(rs2_); t.u1 = u1_; t.u2 = u2_;
        t.rd = 5'(rd_); t.we = we_; t.fl = fl_; t.chk = chk_;
        t.eStall = es; t.eBubble = eb; t.eCnt = ec; t.name = nm;
        vecs.push_back(t);
    endtask

    // Monitor: one DUT output set per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                if (stall !== e.eStall || bubble !== e.eBubble || cnt !== CNT_W'(e.eCnt)) begin
                    failures++;
                    $display("FAIL %s: got stall=%b bubble=%b cnt=%0d, want stall=%b bubble=%b cnt=%0d",
                             e.name, stall, bubble, cnt, e.eStall, e.eBubble, e.eCnt);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; idValid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        use1 = 1'b0; use2 = 1'b0; we = 1'b0; ld = 1'b0; flush = 1'b0;

        // rstn valid rs1 rs2 u1 u2 rd we fl chk  stall bubble cnt
        v(0, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, "rst_first");
        v(0, 1, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, "rst_hold");
        v(1, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, "indep_wr");
        v(1, 1, 4, 5, 1, 1, 0, 0, 0, 1, 0, 0, 0, "indep_rd");
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "idle1");
        v(1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, "raw_wr");
        v(1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, "raw_ex");
        v(1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, "raw_mem");
        v(1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 1, 1, 2, "raw_wb");
        v(1, 1, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3, "raw_issue");
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, "idle2");
        v(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 3, "r0_wr");
        v(1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 3, "r0_rd");
        v(1, 1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 3, "fl_wr");
        v(1, 1, 9, 0, 1, 0, 0, 0, 1, 1, 0, 1, 3, "fl_hazard");
        v(1, 0, 9, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, "fl_after");
        v(1, 1, 0, 0, 0, 0, 10, 1, 1, 1, 0, 1, 3, "fl_squash_wr");
        v(1, 1, 10, 0, 1, 0, 0, 0, 0, 1, 0, 0, 3, "fl_squash_rd");
        v(1, 1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 3, "rm_wr");
        v(1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1, 1, 3, "rm_stall1");
        v(0, 1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 1, 4, "rm_reset");
        v(1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, "rm_issue");
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "idle3");
        v(1, 1, 0, 0, 0, 0, 12, 1, 0, 1, 0, 0, 0, "rs2_wr");
        v(1, 1, 12, 12, 0, 1, 0, 0, 0, 1, 1, 1, 0, "rs2_stall");
        v(1, 1, 12, 12, 0, 0, 0, 0, 0, 1, 0, 0, 1, "rs2_unused");
        v(1, 0, 12, 12, 1, 1, 0, 0, 0, 1, 0, 1, 1, "idle_match");

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst_n = vecs[i].rstn; idValid = vecs[i].valid;
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
            use1 = vecs[i].u1; use2 = vecs[i].u2;
            rd = vecs[i].rd; we = vecs[i].we; flush = vecs[i].fl;
            if (vecs[i].chk) begin
                exp_t e;
                e.eStall = vecs[i].eStall; e.eBubble = vecs[i].eBubble;
                e.eCnt = vecs[i].eCnt; e.name = vecs[i].name;
                sb.push_back(e);
            end
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Scoreboard-based hazard controller for the in-order pipeline.
- Tracks destination registers of instructions in flight in the EX, MEM and WB stages, checks them against the source registers of the instruction in decode, and stalls fetch/decode on a RAW conflict.
- Drives bubble_o, which zeroes the control fields (register-bank write enable, RAM read/write, ALU op) loaded into the decode/execute pipeline buffer. Also clears them on a branch flush.
- Sits beside the decode stage; the fetch PC register and the IF/ID buffer are its other clients.

Parameters:
- REG_AW, 5, register-address width (32 architectural registers; register 0 is hard-wired zero).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid_i  in  1  decode stage holds a valid instruction.
- id_rs1_i  in  REG_AW  source register 1 address.
- id_rs2_i  in  REG_AW  source register 2 address.
- id_use_rs1_i  in  1  instruction reads rs1.
- id_use_rs2_i  in  1  instruction reads rs2.
- id_rd_i  in  REG_AW  destination register address.
- id_we_i  in  1  instruction writes the register bank.
- id_load_i  in  1  instruction is a RAM read (load).
- flush_i  in  1  taken branch; squash the instruction in decode.
- stall_o  out  1  hold PC and IF/ID buffer this cycle.
- bubble_o  out  1  load zeros into the decode/execute buffer control fields this cycle.
- stall_cnt_o  out  CNT_W  cumulative stall cycles, saturating.

Behaviour:
- State: three slots S0 (EX), S1 (MEM), S2 (WB). Each slot holds {valid, rd, load}.
- Match rule: match(r) is true when r != 0 and any valid slot has rd == r.
- Hazard: hazard = id_valid_i AND ((id_use_rs1_i AND match(id_rs1_i)) OR (id_use_rs2_i AND match(id_rs2_i))).
- The register bank does not bypass same-cycle writes, so a match in the S2 (WB) slot counts as a hazard.
- Outputs (combinational from slots and inputs):
  - stall_o = hazard AND NOT flush_i.
  - bubble_o = hazard OR flush_i OR NOT id_valid_i.
- Flush priority: a simultaneous flush and hazard resolves as flush. stall_o=0, bubble_o=1, and the decode instruction is discarded.
- Slot update every rising edge:
  - S2 <= S1, S1 <= S0.
  - S0 <= {1, id_rd_i, id_load_i} when id_valid_i=1, hazard=0, flush_i=0, id_we_i=1 and id_rd_i!=0. Otherwise S0 <= 0.
- Older slots are never cleared by flush; those instructions are committed.
- Latency: a writer blocks dependent readers for exactly the 3 cycles after it leaves decode. The dependent instruction issues on the 4th cycle.
- Stall counter: stall_cnt_o increments by 1 on each edge where stall_o=1. It holds at 2^CNT_W-1 once saturated.
- Reset: while rst_n=0, on the edge all slots are cleared and stall_cnt_o <= 0.
  - While rst_n is sampled low, stall_o=0 and bubble_o=1 regardless of other inputs.
  - A reset mid-stall drops the stall on the first cycle after release, because the slots are empty.
- Writes to register 0 are never recorded; reads of register 0 never stall.

Optional Feature:
- Macro: FORWARD_EN.
- With FORWARD_EN:
  - Adds outputs fwd_a_o and fwd_b_o (2 bits each): 00 = register bank, 01 = EX result (S0), 10 = MEM result (S1), 11 = WB result (S2).
  - On multiple matches the youngest slot wins (S0 > S1 > S2).
  - hazard is restricted to load-use: a source matches S0 and S0.load=1. This gives a single-cycle stall, after which the value forwards from S1 as 10.
  - fwd outputs are 00 when the corresponding use bit is 0, when the source is register 0, or during reset.
- Without FORWARD_EN: the ports are absent and full scoreboard stalling applies as above.

Test Plan:
- Independent instructions: writer rd=3, then reader rs1=4, rs2=5 -> stall_o=0 every cycle; stall_cnt_o stays 0.
- RAW stall: writer rd=7, then reader rs1=7 -> stall_o=1 for 3 consecutive cycles, reader issues on the 4th; stall_cnt_o=3.
- Register 0: writer rd=0, then reader rs2=0 with use_rs2=1 -> no stall; no slot recorded.
- Flush during hazard: writer rd=9, then reader rs1=9 with flush_i=1 in its first decode cycle -> stall_o=0, bubble_o=1; next cycle (id_valid_i=0) bubble_o=1 and no stall.
- Reset mid-stall: writer rd=2, reader rs1=2, assert rst_n=0 for 1 edge during cycle 2 of the stall -> stall_o=0 and bubble_o=1 while low; after release, reader issues with no stall; stall_cnt_o=0.
- FORWARD_EN load-use: load rd=6, then add rs1=6 -> 1 stall cycle, then fwd_a_o=10. Non-load rd=6 followed by a reader -> no stall, fwd_a_o=01.
